lsq_mem_sched: RTL and testbench
================================

// Module: lsq_mem_sched
// PURPOSE
//  Schedules the single processor-memory bus between LSQ traffic.
//  Two requesters share the bus:
//   - load-miss refills from the LQ (DCache miss),
//   - committed store write-throughs from the SQ.
//  Buffers load misses in a small FIFO and keeps at most one load outstanding.
//  Returns refill data to the LQ as the one-hot mem_feedback / mem_data pair.
// PARAMETERS
//  LSQSZ      8  LQ entries; sets the mem_feedback width and the idx width $clog2(LSQSZ)
//  MQ_DEPTH   4  load-miss FIFO depth (power of 2)
//  STARVE_MAX 4  consecutive lost arbitrations before a load wins (only with the _EN macro)
// PORTS
//  clock             in  1        system clock
//  reset             in  1        asynchronous, active-high reset
//  except            in  1        pipeline flush (squash loads only)
//  ld_miss_valid     in  1        LQ miss request
//  ld_miss_idx       in  IW       LQ entry index, IW=$clog2(LSQSZ)
//  ld_miss_addr      in  16       load word address
//  ld_miss_ready     out 1        FIFO not full; push on valid&ready
//  st_wb_valid       in  1        committed store pending
//  st_wb_addr        in  16       store address
//  st_wb_data        in  32       store data
//  st_wb_size        in  2        0=byte 1=half 2=word
//  st_wb_ack         out 1        store accepted by memory this cycle; SQ pops
//  proc2mem_command  out 2        0=NONE 1=LOAD 2=STORE
//  proc2mem_addr     out 16       bus address
//  proc2mem_data     out 32       store data (0 for loads)
//  proc2mem_size     out 2        access size (word for loads)
//  mem2proc_response in  4        nonzero = request accepted, value = tag
//  mem2proc_tag      in  4        tag of returning load data (0 = none)
//  mem2proc_data     in  32       returning load data
//  mem_feedback      out LSQSZ    one-hot LQ entry receiving mem_data
//  mem_data          out 32       refill data
//  busy              out 1        FIFO non-empty or a load is outstanding
// BEHAVIOUR
//  Reset:
//   - state IDLE, FIFO empty, starve counter 0, saved tag 0.
//   - Outputs: command NONE; all other outputs 0 except ld_miss_ready=1.
//  FSM states:
//   - IDLE:  no load outstanding; loads and stores may issue.
//   - WAIT:  one load outstanding; only stores may issue.
//   - DRAIN: load squashed by except; awaiting its tag.
//  Arbitration (IDLE only; WAIT/DRAIN drive stores only):
//   - Re-evaluated every cycle; no request is latched on the bus.
//   - Store wins if st_wb_valid, else the FIFO head load if non-empty.
//   - A request with response==0 is simply re-arbitrated next cycle.
//  Store issue:
//   - Drive STORE/addr/data/size combinationally.
//   - st_wb_ack = (command==STORE && response!=0), same cycle.
//  Load issue:
//   - Drive LOAD with the head addr, size=word.
//   - On response!=0: save tag and idx, pop FIFO, go to WAIT next cycle.
//  WAIT:
//   - When mem2proc_tag==saved tag (nonzero): mem_feedback=1<<idx and
//     mem_data=mem2proc_data, combinational, one cycle; then go to IDLE.
//   - A tag match is never valid in the same cycle as issue.
//  except:
//   - FIFO cleared at the clock edge; a push in the except cycle is dropped.
//   - IDLE with a load being accepted that cycle -> DRAIN, not WAIT.
//   - WAIT -> DRAIN; an except-cycle tag match still completes normally.
//   - Stores are unaffected (already committed); st_wb_ack still fires.
//  DRAIN:
//   - Suppress mem_feedback; on tag match go to IDLE.
//   - Stores may issue; loads are held until IDLE.
//  FIFO:
//   - Pointers wrap mod MQ_DEPTH; count is $clog2(MQ_DEPTH)+1 bits.
//   - ld_miss_ready = !full; no push-through-pop when full.
//   - Simultaneous push and pop when not full: count unchanged.
//  Reset mid-transaction: outstanding tag forgotten; late responses ignored
//   (saved tag 0 never matches).
// CONFIGURATION
//  LSQ_MEM_ANTISTARVE_EN defined:
//   - Counter increments each IDLE cycle in which the FIFO is non-empty
//     and a store wins.
//   - Saturates at STARVE_MAX; at STARVE_MAX the load wins over a store.
//   - Cleared on load acceptance, except, and reset.
//  Undefined: strict store priority, no counter logic.
// TESTING
//  Reset, then one load miss idx=3 addr=0x0040, resp=2 next cycle, tag=2 three cycles later
//   -> LOAD 0x0040 on bus; mem_feedback=8'h08, mem_data=mem2proc_data for exactly one cycle.
//  Push 5 misses, MQ_DEPTH=4, mem never responds
//   -> ld_miss_ready=0 after 4th push; 5th dropped; busy=1.
//  Store and load both pending, resp=1 -> STORE issued, st_wb_ack=1; LOAD issues next cycle.
//   With _EN and STARVE_MAX=4 under continuous stores -> load wins on the 5th IDLE cycle.
//  except in WAIT (tag 5 outstanding), 2 loads queued; tag 5 returns
//   -> mem_feedback stays 0, FIFO empty, state IDLE.
//  Store issued in WAIT with resp=0 for 2 cycles, then resp=3
//   -> STORE held on bus, st_wb_ack=1 only in the accept cycle; outstanding load still completes.

Source files
------------

// File: rtl/lsq_mem_sched_if.sv
// Bus bundle between the LSQ/memory environment and lsq_mem_sched.
// The slave modport is the scheduler's view; master is the environment's.
interface lsq_mem_sched_if #(
  parameter int unsigned LSQSZ = 8
);
  localparam int unsigned IW = $clog2(LSQSZ);

  logic          except;
  logic          ld_miss_valid;
  logic [IW-1:0] ld_miss_idx;
  logic [15:0]   ld_miss_addr;
  logic          ld_miss_ready;
  logic          st_wb_valid;
  logic [15:0]   st_wb_addr;
  logic [31:0]   st_wb_data;
  logic [1:0]    st_wb_size;
  logic          st_wb_ack;
  logic [1:0]    proc2mem_command;
  logic [15:0]   proc2mem_addr;
  logic [31:0]   proc2mem_data;
  logic [1:0]    proc2mem_size;
  logic [3:0]    mem2proc_response;
  logic [3:0]    mem2proc_tag;
  logic [31:0]   mem2proc_data;
  logic [LSQSZ-1:0] mem_feedback;
  logic [31:0]   mem_data;
  logic          busy;

  modport slave (
    input  except, ld_miss_valid, ld_miss_idx, ld_miss_addr,
           st_wb_valid, st_wb_addr, st_wb_data, st_wb_size,
           mem2proc_response, mem2proc_tag, mem2proc_data,
    output ld_miss_ready, st_wb_ack, proc2mem_command, proc2mem_addr,
           proc2mem_data, proc2mem_size, mem_feedback, mem_data, busy
  );

  modport master (
    output except, ld_miss_valid, ld_miss_idx, ld_miss_addr,
           st_wb_valid, st_wb_addr, st_wb_data, st_wb_size,
           mem2proc_response, mem2proc_tag, mem2proc_data,
    input  ld_miss_ready, st_wb_ack, proc2mem_command, proc2mem_addr,
           proc2mem_data, proc2mem_size, mem_feedback, mem_data, busy
  );
endinterface

// File: rtl/lsq_mem_sched.sv
// LSQ memory-bus scheduler: arbitrates committed stores against buffered
// load misses, keeps at most one load outstanding, returns refill data.
// Optional load anti-starvation: define LSQ_MEM_ANTISTARVE_EN.
module lsq_mem_sched #(
  parameter int unsigned LSQSZ      = 8,
  parameter int unsigned MQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  lsq_mem_sched_if.slave bus
);

  localparam int unsigned IW = $clog2(LSQSZ);
  localparam int unsigned PW = $clog2(MQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [15:0]   fifo_addr [MQ_DEPTH];
  logic [IW-1:0] fifo_idx  [MQ_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [3:0]    saved_tag;
  logic [IW-1:0] saved_idx;

  logic fifo_empty, fifo_full, push, pop;
  logic load_win, store_win, load_acc, tag_match, starve_hit;

  assign fifo_empty        = (count == '0);
  assign fifo_full         = (count == CW'(MQ_DEPTH));
  assign bus.ld_miss_ready = !fifo_full;
  assign bus.busy          = !fifo_empty || (state != IDLE);
  assign push              = bus.ld_miss_valid && !fifo_full && !bus.except;
  assign pop               = load_acc;

  // Arbitration, bus drive, refill return and next-state selection
  always_comb begin
    state_nxt             = state;
    load_win              = 1'b0;
    store_win             = 1'b0;
    load_acc              = 1'b0;
    bus.st_wb_ack         = 1'b0;
    bus.proc2mem_command  = CMD_NONE;
    bus.proc2mem_addr     = '0;
    bus.proc2mem_data     = '0;
    bus.proc2mem_size     = 2'd0;
    bus.mem_feedback      = '0;
    bus.mem_data          = '0;
    tag_match = (state != IDLE) && (saved_tag != 4'd0) &&
                (bus.mem2proc_tag == saved_tag);

    if ((state == IDLE) && !fifo_empty && (!bus.st_wb_valid || starve_hit))
      load_win = 1'b1;
    else if (bus.st_wb_valid)
      store_win = 1'b1;

    if (store_win) begin
      bus.proc2mem_command = CMD_STORE;
      bus.proc2mem_addr    = bus.st_wb_addr;
      bus.proc2mem_data    = bus.st_wb_data;
      bus.proc2mem_size    = bus.st_wb_size;
      bus.st_wb_ack        = (bus.mem2proc_response != 4'd0);
    end else if (load_win) begin
      bus.proc2mem_command = CMD_LOAD;
      bus.proc2mem_addr    = fifo_addr[rptr];
      bus.proc2mem_size    = 2'd2;
      load_acc             = (bus.mem2proc_response != 4'd0);
    end

    case (state)
      IDLE: begin
        if (load_acc) state_nxt = bus.except ? DRAIN : WAIT;
      end
      WAIT: begin
        if (tag_match) begin
          bus.mem_feedback = LSQSZ'(1) << saved_idx;
          bus.mem_data     = bus.mem2proc_data;
          state_nxt        = IDLE;
        end else if (bus.except) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_match) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, FIFO pointers/count and outstanding-load bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      saved_tag <= 4'd0;
      saved_idx <= '0;
    end else begin
      state <= state_nxt;
      if (load_acc) begin
        saved_tag <= bus.mem2proc_response;
        saved_idx <= fifo_idx[rptr];
      end
      if (bus.except) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO payload storage
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wptr] <= bus.ld_miss_addr;
      fifo_idx[wptr]  <= bus.ld_miss_idx;
    end
  end

`ifdef LSQ_MEM_ANTISTARVE_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

  // Count IDLE cycles in which a store beat a waiting load
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (bus.except || load_acc)
      starve_cnt <= '0;
    else if ((state == IDLE) && !fifo_empty && store_win && !starve_hit)
      starve_cnt <= starve_cnt + SW'(1);
  end
`else
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign starve_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_lsq_mem_sched.sv
// Self-checking bench for lsq_mem_sched: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_lsq_mem_sched;

  localparam int unsigned LSQSZ      = 8;
  localparam int unsigned MQ_DEPTH   = 4;
  localparam int unsigned STARVE_MAX = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lsq_mem_sched_if #(.LSQSZ(LSQSZ)) bus();

  lsq_mem_sched #(.LSQSZ(LSQSZ), .MQ_DEPTH(MQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] addr;
  } ent_t;

  // Reference model: pending misses plus the one outstanding load
  ent_t mq[$];
  bit   m_out, m_sq;
  int   m_tag, m_idx, m_starve;

  logic [31:0] e_cmd, e_addr, e_data, e_size, e_ack, e_fb, e_mdata, e_ready, e_busy;
  bit          e_lw, e_match;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_out = 0; m_sq = 0; m_tag = 0; m_idx = 0; m_starve = 0;
  endfunction

  function automatic void model_eval();
    bit starve_ok;
    starve_ok = 0;
`ifdef LSQ_MEM_ANTISTARVE_EN
    starve_ok = (m_starve >= STARVE_MAX);
`endif
    e_lw    = !m_out && (mq.size() > 0) && (!bus.st_wb_valid || starve_ok);
    e_cmd   = (bus.st_wb_valid && !e_lw) ? 2 : (e_lw ? 1 : 0);
    e_addr  = (e_cmd == 2) ? 32'(bus.st_wb_addr) : ((e_cmd == 1) ? 32'(mq[0].addr) : 0);
    e_data  = (e_cmd == 2) ? bus.st_wb_data : 0;
    e_size  = (e_cmd == 2) ? 32'(bus.st_wb_size) : ((e_cmd == 1) ? 2 : 0);
    e_ack   = ((e_cmd == 2) && (bus.mem2proc_response != 0)) ? 1 : 0;
    e_match = m_out && (m_tag != 0) && (int'(bus.mem2proc_tag) == m_tag);
    e_fb    = (e_match && !m_sq) ? (32'(1) << m_idx) : 0;
    e_mdata = (e_match && !m_sq) ? bus.mem2proc_data : 0;
    e_ready = (mq.size() < MQ_DEPTH) ? 1 : 0;
    e_busy  = ((mq.size() > 0) || m_out) ? 1 : 0;
  endfunction

  function automatic void model_update();
    bit   acc;
    ent_t e;
    acc = e_lw && (bus.mem2proc_response != 0);
    if (e_match) m_out = 0;
    else if (bus.except && m_out) m_sq = 1;
    if (acc) begin
      e      = mq.pop_front();
      m_out  = 1;
      m_tag  = int'(bus.mem2proc_response);
      m_idx  = int'(e.idx);
      m_sq   = bus.except;
    end
`ifdef LSQ_MEM_ANTISTARVE_EN
    if (bus.except || acc) m_starve = 0;
    else if (!m_out && (mq.size() > 0) && (e_cmd == 2) && (m_starve < STARVE_MAX)) m_starve++;
`endif
    if (bus.except) mq.delete();
    else if (bus.ld_miss_valid && (e_ready == 1)) begin
      e.idx  = bus.ld_miss_idx;
      e.addr = bus.ld_miss_addr;
      mq.push_back(e);
    end
  endfunction

  task automatic clear_inputs();
    bus.except            = 1'b0;
    bus.ld_miss_valid     = 1'b0;
    bus.ld_miss_idx       = 3'd0;
    bus.ld_miss_addr      = 16'd0;
    bus.st_wb_valid       = 1'b0;
    bus.st_wb_addr        = 16'd0;
    bus.st_wb_data        = 32'd0;
    bus.st_wb_size        = 2'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd0;
    bus.mem2proc_data     = 32'd0;
  endtask

  task automatic settle_and_check();
    #2;
    model_eval();
    check("cmd",   32'(bus.proc2mem_command), e_cmd);
    check("addr",  32'(bus.proc2mem_addr),    e_addr);
    check("data",  bus.proc2mem_data,         e_data);
    check("size",  32'(bus.proc2mem_size),    e_size);
    check("ack",   32'(bus.st_wb_ack),        e_ack);
    check("fb",    32'(bus.mem_feedback),     e_fb);
    check("mdata", bus.mem_data,              e_mdata);
    check("ready", 32'(bus.ld_miss_ready),    e_ready);
    check("busy",  32'(bus.busy),             e_busy);
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    check("rst_cmd",   32'(bus.proc2mem_command), 32'd0);
    check("rst_ready", 32'(bus.ld_miss_ready),    32'd1);
    check("rst_busy",  32'(bus.busy),             32'd0);
    check("rst_fb",    32'(bus.mem_feedback),     32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_only(input logic [2:0] idx, input logic [15:0] addr);
    clear_inputs();
    bus.ld_miss_valid = 1'b1;
    bus.ld_miss_idx   = idx;
    bus.ld_miss_addr  = addr;
    settle_and_check();
    tick();
  endtask

  typedef struct {
    bit          ld_v;
    logic [2:0]  idx;
    logic [15:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [31:0] mdata;
    logic [1:0]  x_cmd;
    logic [15:0] x_addr;
    logic [7:0]  x_fb;
    logic [31:0] x_mdata;
    bit          x_busy;
  } vec_t;

  vec_t vt[6];

  initial begin
    clear_inputs();
    do_reset();

    // Single load miss idx=3 addr=0x0040, accepted with tag 2, returned 3 cycles later
    vt[0] = '{1, 3'd3, 16'h0040, 4'd0, 4'd0, 32'h0,        2'd0, 16'h0000, 8'h00, 32'h0,        0};
    vt[1] = '{0, 3'd0, 16'h0000, 4'd2, 4'd0, 32'h0,        2'd1, 16'h0040, 8'h00, 32'h0,        1};
    vt[2] = '{0, 3'd0, 16'h0000, 4'd0, 4'd0, 32'h0,        2'd0, 16'h0000, 8'h00, 32'h0,        1};
    vt[3] = '{0, 3'd0, 16'h0000, 4'd0, 4'd0, 32'h0,        2'd0, 16'h0000, 8'h00, 32'h0,        1};
    vt[4] = '{0, 3'd0, 16'h0000, 4'd0, 4'd2, 32'hcafef00d, 2'd0, 16'h0000, 8'h08, 32'hcafef00d, 1};
    vt[5] = '{0, 3'd0, 16'h0000, 4'd0, 4'd2, 32'h12345678, 2'd0, 16'h0000, 8'h00, 32'h0,        0};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      bus.ld_miss_valid     = vt[i].ld_v;
      bus.ld_miss_idx       = vt[i].idx;
      bus.ld_miss_addr      = vt[i].addr;
      bus.mem2proc_response = vt[i].resp;
      bus.mem2proc_tag      = vt[i].tag;
      bus.mem2proc_data     = vt[i].mdata;
      settle_and_check();
      check($sformatf("vec%0d_cmd", i),   32'(bus.proc2mem_command), 32'(vt[i].x_cmd));
      check($sformatf("vec%0d_addr", i),  32'(bus.proc2mem_addr),    32'(vt[i].x_addr));
      check($sformatf("vec%0d_fb", i),    32'(bus.mem_feedback),     32'(vt[i].x_fb));
      check($sformatf("vec%0d_mdata", i), bus.mem_data,              vt[i].x_mdata);
      check($sformatf("vec%0d_busy", i),  32'(bus.busy),             32'(vt[i].x_busy));
      tick();
    end

    // FIFO fill: five pushes, memory never responds
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      bus.ld_miss_valid = 1'b1;
      bus.ld_miss_idx   = 3'(k);
      bus.ld_miss_addr  = 16'(16'h0100 + k);
      settle_and_check();
      check($sformatf("fill%0d_ready", k), 32'(bus.ld_miss_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    clear_inputs();
    settle_and_check();
    check("fill_busy",  32'(bus.busy),          32'd1);
    check("fill_head",  32'(bus.proc2mem_addr), 32'h0100);
    tick();
    clear_inputs();
    bus.except = 1'b1;
    settle_and_check();
    tick();
    clear_inputs();
    settle_and_check();
    check("flush_busy",  32'(bus.busy),          32'd0);
    check("flush_ready", 32'(bus.ld_miss_ready), 32'd1);
    tick();

    // Store beats pending load; load issues the following cycle
    push_only(3'd5, 16'h0200);
    clear_inputs();
    bus.st_wb_valid = 1'b1; bus.st_wb_addr = 16'h0300;
    bus.st_wb_data  = 32'ha5a5a5a5; bus.st_wb_size = 2'd2;
    bus.mem2proc_response = 4'd1;
    settle_and_check();
    check("prio_cmd", 32'(bus.proc2mem_command), 32'd2);
    check("prio_ack", 32'(bus.st_wb_ack),        32'd1);
    tick();
    clear_inputs();
    bus.mem2proc_response = 4'd1;
    settle_and_check();
    check("prio_ld_cmd",  32'(bus.proc2mem_command), 32'd1);
    check("prio_ld_addr", 32'(bus.proc2mem_addr),    32'h0200);
    tick();
    clear_inputs();
    settle_and_check();
    tick();
    clear_inputs();
    bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 32'h0badf00d;
    settle_and_check();
    check("prio_fb", 32'(bus.mem_feedback), 32'h20);
    tick();

`ifdef LSQ_MEM_ANTISTARVE_EN
    // Continuous stores: waiting load wins on the fifth IDLE cycle
    push_only(3'd4, 16'h0600);
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      bus.st_wb_valid = 1'b1; bus.st_wb_addr = 16'(16'h0700 + c);
      bus.st_wb_data  = 32'(c); bus.mem2proc_response = 4'd1;
      settle_and_check();
      check($sformatf("starve%0d_cmd", c), 32'(bus.proc2mem_command), (c < 4) ? 32'd2 : 32'd1);
      tick();
    end
    clear_inputs();
    settle_and_check();
    tick();
    clear_inputs();
    bus.mem2proc_tag = 4'd1;
    settle_and_check();
    check("starve_fb", 32'(bus.mem_feedback), 32'h10);
    tick();
`endif

    // except while WAIT (tag 5) with two loads queued; squashed tag returns
    push_only(3'd2, 16'h0400);
    clear_inputs();
    bus.mem2proc_response = 4'd5;
    settle_and_check();
    check("sq_issue", 32'(bus.proc2mem_command), 32'd1);
    tick();
    push_only(3'd6, 16'h0410);
    push_only(3'd7, 16'h0420);
    clear_inputs();
    bus.except = 1'b1;
    settle_and_check();
    tick();
    clear_inputs();
    bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 32'h55555555;
    settle_and_check();
    check("sq_fb",    32'(bus.mem_feedback), 32'd0);
    check("sq_mdata", bus.mem_data,          32'd0);
    tick();
    clear_inputs();
    settle_and_check();
    check("sq_busy", 32'(bus.busy),             32'd0);
    check("sq_cmd",  32'(bus.proc2mem_command), 32'd0);
    tick();

    // Store held on bus during WAIT until accepted; load still completes
    push_only(3'd1, 16'h0500);
    clear_inputs();
    bus.mem2proc_response = 4'd4;
    settle_and_check();
    tick();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      bus.st_wb_valid = 1'b1; bus.st_wb_addr = 16'h0800;
      bus.st_wb_data  = 32'h11223344; bus.st_wb_size = 2'd1;
      bus.mem2proc_response = (c == 2) ? 4'd3 : 4'd0;
      settle_and_check();
      check($sformatf("hold%0d_cmd", c),  32'(bus.proc2mem_command), 32'd2);
      check($sformatf("hold%0d_addr", c), 32'(bus.proc2mem_addr),    32'h0800);
      check($sformatf("hold%0d_ack", c),  32'(bus.st_wb_ack),        (c == 2) ? 32'd1 : 32'd0);
      tick();
    end
    clear_inputs();
    bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 32'h99887766;
    settle_and_check();
    check("hold_fb",    32'(bus.mem_feedback), 32'h02);
    check("hold_mdata", bus.mem_data,          32'h99887766);
    tick();

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      clear_inputs();
      bus.ld_miss_valid = 1'($urandom_range(0, 1));
      bus.ld_miss_idx   = 3'($urandom_range(0, 7));
      bus.ld_miss_addr  = 16'($urandom);
      bus.st_wb_valid   = ($urandom_range(0, 2) == 0);
      bus.st_wb_addr    = 16'($urandom);
      bus.st_wb_data    = $urandom;
      bus.st_wb_size    = 2'($urandom_range(0, 2));
      bus.mem2proc_response = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (m_out && ($urandom_range(0, 3) == 0)) bus.mem2proc_tag = 4'(m_tag);
      else if ($urandom_range(0, 7) == 0)       bus.mem2proc_tag = 4'($urandom_range(1, 15));
      bus.mem2proc_data = $urandom;
      bus.except        = ($urandom_range(0, 24) == 0);
      settle_and_check();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
